// File: rtl/dmem_pkg.sv
// Shared funct3 encodings, counter width and FSM state type for the data memory controller.
package dmem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering for RV32 loads/stores: write mask, shifted store data,
// extended load value, and misaligned/illegal classification.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [2:0]  i_funct3,
   input  logic        i_we,
   input  logic [1:0]  i_off,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_rdword,
   output logic [3:0]  o_mask_c,
   output logic [31:0] o_wdata_c,
   output logic [31:0] o_rdata_c,
   output logic        o_misalign_c,
   output logic        o_illegal_c
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Halfwords always come from off[1]; the low offset bit only flags misalignment.
   assign w_byte = 8'(i_rdword >> {i_off, 3'b000});
   assign w_half = i_off[1] ? i_rdword[31:16] : i_rdword[15:0];

   always_comb begin
      o_mask_c     = 4'b0000;
      o_wdata_c    = 32'h0;
      o_rdata_c    = 32'h0;
      o_misalign_c = 1'b0;
      o_illegal_c  = 1'b0;
      case (i_funct3)
         F3_B: begin
            o_mask_c  = 4'b0001 << i_off;
            o_wdata_c = {4{i_wdata[7:0]}};
            o_rdata_c = {{24{w_byte[7]}}, w_byte};
         end
         F3_BU: begin
            o_rdata_c   = {24'h0, w_byte};
            o_illegal_c = i_we;
         end
         F3_H: begin
            o_mask_c     = i_off[1] ? 4'b1100 : 4'b0011;
            o_wdata_c    = {2{i_wdata[15:0]}};
            o_rdata_c    = {{16{w_half[15]}}, w_half};
            o_misalign_c = i_off[0];
         end
         F3_HU: begin
            o_rdata_c    = {16'h0, w_half};
            o_misalign_c = i_off[0];
            o_illegal_c  = i_we;
         end
         F3_W: begin
            o_mask_c     = 4'b1111;
            o_wdata_c    = i_wdata;
            o_rdata_c    = i_rdword;
            o_misalign_c = |i_off;
         end
         default: o_illegal_c = 1'b1;
      endcase
   end

endmodule

// File: rtl/dmem_ctrl.sv
// RV32 byte-addressable data memory with valid/ready request, registered response and
// LATENCY wait states. Define DMEM_MISALIGN_TRAP_EN to fault misaligned accesses.
module dmem_ctrl
   import dmem_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned MEM_SIZE   = 256,
   parameter int unsigned LATENCY    = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [2:0]            req_funct3,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  rsp_valid,
   output logic [31:0]           rsp_rdata,
   output logic                  rsp_err
);

   localparam int unsigned IDX_W = $clog2(MEM_SIZE);
   localparam int unsigned LA_W  = IDX_W + 2;

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_we;
   logic [2:0]        r_funct3;
   logic [LA_W-1:0]   r_addr;
   logic [31:0]       r_wdata;
   logic              r_req_ready;
   logic              r_rsp_valid;
   logic [31:0]       r_rsp_rdata;
   logic              r_rsp_err;
   logic [31:0]       r_mem [MEM_SIZE];

   logic              w_we;
   logic [2:0]        w_funct3;
   logic [LA_W-1:0]   w_addr;
   logic [31:0]       w_wdata;
   logic [IDX_W-1:0]  w_idx;
   logic [31:0]       w_rdword;
   logic [3:0]        w_mask;
   logic [31:0]       w_wdata_sh;
   logic [31:0]       w_rdata_ext;
   logic              w_misalign;
   logic              w_illegal;
   logic              w_err;
   logic              w_commit;
   logic              w_wr_en;
   logic [31:0]       w_rsp_data;
   logic              w_unused;

   assign w_unused = ^req_addr[ADDR_WIDTH-1:LA_W];

   // With zero latency the commit edge is the accept edge, so the live request is used.
   always_comb begin
      w_we     = r_we;
      w_funct3 = r_funct3;
      w_addr   = r_addr;
      w_wdata  = r_wdata;
      if (r_state == IDLE) begin
         w_we     = req_we;
         w_funct3 = req_funct3;
         w_addr   = req_addr[LA_W-1:0];
         w_wdata  = req_wdata;
      end
   end

   assign w_idx    = w_addr[LA_W-1:2];
   assign w_rdword = r_mem[w_idx];

   dmem_lane_align u_align (
      .i_funct3     (w_funct3),
      .i_we         (w_we),
      .i_off        (w_addr[1:0]),
      .i_wdata      (w_wdata),
      .i_rdword     (w_rdword),
      .o_mask_c     (w_mask),
      .o_wdata_c    (w_wdata_sh),
      .o_rdata_c    (w_rdata_ext),
      .o_misalign_c (w_misalign),
      .o_illegal_c  (w_illegal)
   );

`ifdef DMEM_MISALIGN_TRAP_EN
   assign w_err = w_illegal | w_misalign;
`else
   assign w_err = w_illegal;
   logic w_unused_misalign;
   assign w_unused_misalign = w_misalign;
`endif

   assign w_commit   = ((r_state == IDLE) && req_valid && (LATENCY == 0)) ||
                       ((r_state == WAIT) && (r_cnt == '0));
   assign w_wr_en    = w_commit && w_we && !w_err;
   assign w_rsp_data = (w_we || w_err) ? 32'h0 : w_rdata_ext;

   // Request sequencing, wait-state counter and registered response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_we        <= 1'b0;
         r_funct3    <= 3'b000;
         r_addr      <= '0;
         r_wdata     <= 32'h0;
         r_req_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= 32'h0;
         r_rsp_err   <= 1'b0;
      end else begin
         r_rsp_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (req_valid) begin
                  r_we        <= req_we;
                  r_funct3    <= req_funct3;
                  r_addr      <= req_addr[LA_W-1:0];
                  r_wdata     <= req_wdata;
                  r_req_ready <= 1'b0;
                  if (LATENCY > 0) begin
                     r_state <= WAIT;
                     r_cnt   <= CNT_W'(LATENCY - 1);
                  end else begin
                     r_state     <= RESP;
                     r_rsp_valid <= 1'b1;
                  end
               end
            end
            WAIT: begin
               if (r_cnt == '0) begin
                  r_state     <= RESP;
                  r_rsp_valid <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            RESP: begin
               r_state     <= IDLE;
               r_req_ready <= 1'b1;
            end
            default: begin
               r_state     <= IDLE;
               r_req_ready <= 1'b1;
            end
         endcase
         if (w_commit) begin
            r_rsp_rdata <= w_rsp_data;
            r_rsp_err   <= w_err;
         end
      end
   end

   // Word RAM with per-byte write enables; contents are intentionally not reset.
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (w_mask[b]) r_mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
         end
      end
   end

   assign req_ready = r_req_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed cases plus randomized accesses against a byte-array model.
`timescale 1ns/1ps
module tb_dmem_ctrl;

   localparam int LAT       = 1;
   localparam int MEM_BYTES = 256 * 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;

   logic        req_valid0, req_ready0, req_we0;
   logic [2:0]  req_funct30;
   logic [31:0] req_addr0, req_wdata0;
   logic        rsp_valid0, rsp_err0;
   logic [31:0] rsp_rdata0;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] m_mem [MEM_BYTES];

   always #5 clk = ~clk;

   dmem_ctrl #(.ADDR_WIDTH(32), .MEM_SIZE(256), .LATENCY(LAT)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   dmem_ctrl #(.ADDR_WIDTH(32), .MEM_SIZE(256), .LATENCY(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
      .req_funct3(req_funct30), .req_addr(req_addr0), .req_wdata(req_wdata0),
      .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Reference model: memory as a flat byte array, accesses sized and extended arithmetically.
   task automatic model_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, output logic [31:0] rd, output logic er);
      int size; bit sgn; bit ill; bit mis; int base; logic [31:0] v;
      size = 4; sgn = 0; ill = 0;
      case (f3)
         3'd0: begin size = 1; sgn = 1; end
         3'd1: begin size = 2; sgn = 1; end
         3'd2: size = 4;
         3'd4: begin size = 1; ill = we; end
         3'd5: begin size = 2; ill = we; end
         default: ill = 1;
      endcase
      base = int'(addr % MEM_BYTES);
      mis  = (base % size) != 0;
`ifdef DMEM_MISALIGN_TRAP_EN
      er = ill || mis;
`else
      er = ill;
`endif
      base = base - (base % size);
      rd = 32'h0;
      if (!er) begin
         if (we) begin
            for (int i = 0; i < size; i++) m_mem[base+i] = 8'(wdata >> (8*i));
         end else begin
            v = 32'h0;
            for (int i = 0; i < size; i++) v = v | (32'(m_mem[base+i]) << (8*i));
            if (sgn && v[8*size-1]) v = v | ~((32'h1 << (8*size)) - 32'h1);
            rd = v;
         end
      end
   endtask

   // One bus transaction on the LATENCY=1 instance with protocol timing checks.
   task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, output logic [31:0] rd, output logic er);
      int n; int lat; int rdy_low;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
      n = 0;
      while (!req_ready && n < 20) begin @(negedge clk); n++; end
      check_eq("accept", 32'(req_ready), 32'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
      req_addr = $urandom; req_wdata = $urandom;
      lat = 0; rdy_low = 0;
      do begin
         @(negedge clk);
         lat++;
         if (!req_ready) rdy_low++;
      end while (!rsp_valid && lat < 20);
      rd = rsp_rdata; er = rsp_err;
      check_eq("rsp_latency", 32'(lat), 32'(LAT + 1));
      check_eq("ready_low_cycles", 32'(rdy_low), 32'(LAT + 1));
      @(negedge clk);
      check_eq("rsp_one_cycle", 32'(rsp_valid), 32'd0);
      check_eq("ready_after_rsp", 32'(req_ready), 32'd1);
   endtask

   task automatic tb_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, output logic [31:0] rd, output logic er);
      logic [31:0] mrd; logic mer;
      do_access(we, f3, addr, wdata, rd, er);
      model_access(we, f3, addr, wdata, mrd, mer);
      check_eq("rdata_vs_model", rd, mrd);
      check_eq("err_vs_model", 32'(er), 32'(mer));
   endtask

   initial begin
      logic [31:0] rd; logic er; logic [31:0] exp0;
      rst_n = 1'b0;
      req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
      req_valid0 = 0; req_we0 = 0; req_funct30 = 0; req_addr0 = 0; req_wdata0 = 0;
      repeat (3) @(negedge clk);
      check_eq("rst_ready", 32'(req_ready), 32'd1);
      check_eq("rst_valid", 32'(rsp_valid), 32'd0);
      check_eq("rst_rdata", rsp_rdata, 32'h0);
      check_eq("rst_err", 32'(rsp_err), 32'd0);
      rst_n = 1'b1;

      for (int w = 0; w < 16; w++) tb_access(1'b1, 3'b010, 32'(w*4), $urandom, rd, er);

      tb_access(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er);
      tb_access(1'b0, 3'b010, 32'h10, 32'h0, rd, er);
      check_eq("lw_deadbeef", rd, 32'hDEADBEEF);
      tb_access(1'b1, 3'b000, 32'h13, 32'h0000005A, rd, er);
      tb_access(1'b0, 3'b010, 32'h10, 32'h0, rd, er);
      check_eq("sb_lane3", rd, 32'h5AADBEEF);
      tb_access(1'b0, 3'b000, 32'h13, 32'h0, rd, er);
      check_eq("lb_13", rd, 32'h0000005A);
      tb_access(1'b0, 3'b000, 32'h12, 32'h0, rd, er);
      check_eq("lb_12", rd, 32'hFFFFFFAD);
      tb_access(1'b0, 3'b100, 32'h12, 32'h0, rd, er);
      check_eq("lbu_12", rd, 32'h000000AD);

      tb_access(1'b0, 3'b010, 32'h20, 32'h0, rd, er);
      exp0 = rd;
      tb_access(1'b1, 3'b001, 32'h22, 32'h00008001, rd, er);
      tb_access(1'b0, 3'b001, 32'h22, 32'h0, rd, er);
      check_eq("lh_22", rd, 32'hFFFF8001);
      tb_access(1'b0, 3'b101, 32'h22, 32'h0, rd, er);
      check_eq("lhu_22", rd, 32'h00008001);
      tb_access(1'b0, 3'b010, 32'h20, 32'h0, rd, er);
      check_eq("sh_keeps_low", rd, {16'h8001, exp0[15:0]});

      tb_access(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er);
      tb_access(1'b0, 3'b010, 32'h11, 32'h0, rd, er);
`ifdef DMEM_MISALIGN_TRAP_EN
      check_eq("mis_lw_rdata", rd, 32'h0);
      check_eq("mis_lw_err", 32'(er), 32'd1);
`else
      check_eq("mis_lw_rdata", rd, 32'hDEADBEEF);
      check_eq("mis_lw_err", 32'(er), 32'd0);
`endif
      tb_access(1'b0, 3'b011, 32'h10, 32'h0, rd, er);
      check_eq("ill_f3_err", 32'(er), 32'd1);
      check_eq("ill_f3_rdata", rd, 32'h0);

      tb_access(1'b1, 3'b010, 32'h400, 32'h12345678, rd, er);
      tb_access(1'b0, 3'b010, 32'h0, 32'h0, rd, er);
      check_eq("wrap_lw", rd, 32'h12345678);

      // Store aborted by reset while waiting: memory and model must both stay untouched.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h0; req_wdata = 32'h0;
      @(posedge clk);
      #1 req_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check_eq("wrst_ready", 32'(req_ready), 32'd1);
      check_eq("wrst_valid", 32'(rsp_valid), 32'd0);
      check_eq("wrst_rdata", rsp_rdata, 32'h0);
      check_eq("wrst_err", 32'(rsp_err), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tb_access(1'b0, 3'b010, 32'h0, 32'h0, rd, er);
      check_eq("after_rst_lw", rd, 32'h12345678);

      for (int k = 0; k < 150; k++) begin
         tb_access(1'($urandom), 3'($urandom),
                   ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 63)), $urandom, rd, er);
      end

      // Zero-latency instance with req_valid held: accept every other edge, respond next cycle.
      for (int i = 0; i <= 16; i++) begin
         @(negedge clk);
         if (i % 2 == 1) begin
            check_eq("l0_ready_busy", 32'(req_ready0), 32'd0);
            check_eq("l0_valid", 32'(rsp_valid0), 32'd1);
            check_eq("l0_rdata", rsp_rdata0, ((i - 1) / 2 < 4) ? 32'h0 : 32'hA000_0000 + 32'((i - 1) / 2 - 4));
            check_eq("l0_err", 32'(rsp_err0), 32'd0);
         end else begin
            check_eq("l0_ready_idle", 32'(req_ready0), 32'd1);
            check_eq("l0_valid_idle", 32'(rsp_valid0), 32'd0);
         end
         if (i % 2 == 0 && i < 16) begin
            req_valid0  = 1'b1;
            req_we0     = (i / 2) < 4;
            req_funct30 = 3'b010;
            req_addr0   = 32'(4 * ((i / 2) % 4));
            req_wdata0  = 32'hA000_0000 + 32'((i / 2) % 4);
         end
      end
      req_valid0 = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
